// File: rtl/rv64_decode_unit_if.sv
// Fetch-to-decode instruction bundle and decoded-entry bundle.
// master = IF/ID side driving the instruction, slave = the decoder.
interface rv64_decode_unit_if #(
    parameter int PC_W = 40,
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [PC_W-1:0] pc_i;
    logic [31:0]     inst_i;
    logic            ex_valid_i;
    logic [3:0]      ex_cause_i;
    logic [XLEN-1:0] ex_origin_i;
    logic            bpred_taken_i;
    logic [PC_W-1:0] bpred_addr_i;

    logic            valid_o;
    logic [PC_W-1:0] pc_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic            use_rs1_o;
    logic            use_rs2_o;
    logic            regfile_we_o;
    logic [XLEN-1:0] imm_o;
    logic            use_imm_o;
    logic            use_pc_o;
    logic [1:0]      unit_o;
    logic [4:0]      op_o;
    logic [1:0]      mem_size_o;
    logic            mem_signed_o;
    logic            ex_valid_o;
    logic [3:0]      ex_cause_o;
    logic [XLEN-1:0] ex_origin_o;
    logic            bpred_taken_o;
    logic [PC_W-1:0] bpred_addr_o;

    modport master (
        output valid_i, pc_i, inst_i, ex_valid_i, ex_cause_i,
               ex_origin_i, bpred_taken_i, bpred_addr_i,
        input  valid_o, pc_o, rs1_o, rs2_o, rd_o, use_rs1_o,
               use_rs2_o, regfile_we_o, imm_o, use_imm_o, use_pc_o,
               unit_o, op_o, mem_size_o, mem_signed_o, ex_valid_o,
               ex_cause_o, ex_origin_o, bpred_taken_o, bpred_addr_o
    );

    modport slave (
        input  valid_i, pc_i, inst_i, ex_valid_i, ex_cause_i,
               ex_origin_i, bpred_taken_i, bpred_addr_i,
        output valid_o, pc_o, rs1_o, rs2_o, rd_o, use_rs1_o,
               use_rs2_o, regfile_we_o, imm_o, use_imm_o, use_pc_o,
               unit_o, op_o, mem_size_o, mem_signed_o, ex_valid_o,
               ex_cause_o, ex_origin_o, bpred_taken_o, bpred_addr_o
    );
endinterface

// File: rtl/rv64_decode_unit.sv
// RV64I instruction decoder: combinational decode into a single
// output register (latency 1), with illegal-instruction detection.
module rv64_decode_unit #(
    parameter int PC_W = 40,
    parameter int XLEN = 64
) (
    input logic clk_i,
    input logic rst_i,
    rv64_decode_unit_if.slave bus
);
    localparam logic [1:0] U_ALU = 2'd0, U_BR = 2'd1;
    localparam logic [1:0] U_MEM = 2'd2, U_SYS = 2'd3;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1;
    localparam logic [4:0] OP_SLL = 5'd2, OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5;
    localparam logic [4:0] OP_SRL = 5'd6, OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8, OP_AND = 5'd9;
    localparam logic [4:0] OP_ADDW = 5'd10, OP_SUBW = 5'd11;
    localparam logic [4:0] OP_SLLW = 5'd12, OP_SRLW = 5'd13;
    localparam logic [4:0] OP_SRAW = 5'd14, OP_LUI = 5'd15;
    localparam logic [4:0] OP_AUIPC = 5'd16, OP_JAL = 5'd17;
    localparam logic [4:0] OP_JALR = 5'd18, OP_BEQ = 5'd19;
    localparam logic [4:0] OP_BNE = 5'd20, OP_BLT = 5'd21;
    localparam logic [4:0] OP_BGE = 5'd22, OP_BLTU = 5'd23;
    localparam logic [4:0] OP_BGEU = 5'd24, OP_LOAD = 5'd25;
    localparam logic [4:0] OP_STORE = 5'd26, OP_FENCE = 5'd27;
    localparam logic [4:0] OP_SYS = 5'd28;

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    assign inst = bus.inst_i;
    assign opc  = inst[6:0];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [XLEN-1:0] sh6, sh5;
    assign i_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign s_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign b_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                    inst[30:25], inst[11:8], 1'b0};
    assign u_imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign j_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                    inst[20], inst[30:21], 1'b0};
    assign sh6   = {{(XLEN-6){1'b0}}, inst[25:20]};
    assign sh5   = {{(XLEN-5){1'b0}}, inst[24:20]};

    logic [1:0]      d_unit, d_msize;
    logic [4:0]      d_op;
    logic [XLEN-1:0] d_imm;
    logic d_rs1, d_rs2, d_uimm, d_upc, d_wr, d_msgn, ill;

    always_comb begin
        d_unit = U_ALU; d_op = OP_ADD; d_imm = '0;
        d_rs1 = 1'b0; d_rs2 = 1'b0; d_uimm = 1'b0; d_upc = 1'b0;
        d_wr = 1'b0; d_msize = 2'd0; d_msgn = 1'b0; ill = 1'b0;
        unique case (opc)
            7'h13: begin
                d_rs1 = 1'b1; d_uimm = 1'b1; d_wr = 1'b1; d_imm = i_imm;
                unique case (f3)
                    3'd0: d_op = OP_ADD;
                    3'd1: begin
                        d_op = OP_SLL; d_imm = sh6;
                        ill = inst[31:26] != 6'd0;
                    end
                    3'd2: d_op = OP_SLT;
                    3'd3: d_op = OP_SLTU;
                    3'd4: d_op = OP_XOR;
                    3'd5: begin
                        d_op = inst[30] ? OP_SRA : OP_SRL; d_imm = sh6;
                        ill = {inst[31], inst[29:26]} != 5'd0;
                    end
                    3'd6: d_op = OP_OR;
                    default: d_op = OP_AND;
                endcase
            end
            7'h1B: begin
                d_rs1 = 1'b1; d_uimm = 1'b1; d_wr = 1'b1; d_imm = i_imm;
                unique case (f3)
                    3'd0: d_op = OP_ADDW;
                    3'd1: begin
                        d_op = OP_SLLW; d_imm = sh5;
                        ill = f7 != 7'd0;
                    end
                    3'd5: begin
                        d_op = inst[30] ? OP_SRAW : OP_SRLW; d_imm = sh5;
                        ill = {inst[31], inst[29:25]} != 6'd0;
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'h33: begin
                d_rs1 = 1'b1; d_rs2 = 1'b1; d_wr = 1'b1;
                unique case (f3)
                    3'd0: d_op = OP_ADD;
                    3'd1: d_op = OP_SLL;
                    3'd2: d_op = OP_SLT;
                    3'd3: d_op = OP_SLTU;
                    3'd4: d_op = OP_XOR;
                    3'd5: d_op = OP_SRL;
                    3'd6: d_op = OP_OR;
                    default: d_op = OP_AND;
                endcase
                // funct7 0x20 only legal for SUB/SRA, anything else is M/reserved
                if (f7 == 7'h20) begin
                    if (f3 == 3'd0) d_op = OP_SUB;
                    else if (f3 == 3'd5) d_op = OP_SRA;
                    else ill = 1'b1;
                end else if (f7 != 7'd0) begin
                    ill = 1'b1;
                end
            end
            7'h3B: begin
                d_rs1 = 1'b1; d_rs2 = 1'b1; d_wr = 1'b1;
                unique case (f3)
                    3'd0: begin
                        d_op = inst[30] ? OP_SUBW : OP_ADDW;
                        ill = {inst[31], inst[29:25]} != 6'd0;
                    end
                    3'd1: begin
                        d_op = OP_SLLW; ill = f7 != 7'd0;
                    end
                    3'd5: begin
                        d_op = inst[30] ? OP_SRAW : OP_SRLW;
                        ill = {inst[31], inst[29:25]} != 6'd0;
                    end
                    default: ill = 1'b1;
                endcase
            end
            7'h37: begin
                d_op = OP_LUI; d_imm = u_imm; d_uimm = 1'b1; d_wr = 1'b1;
            end
            7'h17: begin
                d_op = OP_AUIPC; d_imm = u_imm; d_uimm = 1'b1;
                d_upc = 1'b1; d_wr = 1'b1;
            end
            7'h6F: begin
                d_unit = U_BR; d_op = OP_JAL; d_imm = j_imm;
                d_upc = 1'b1; d_wr = 1'b1;
            end
            7'h67: begin
                d_unit = U_BR; d_op = OP_JALR; d_imm = i_imm;
                d_rs1 = 1'b1; d_wr = 1'b1; ill = f3 != 3'd0;
            end
            7'h63: begin
                d_unit = U_BR; d_imm = b_imm; d_rs1 = 1'b1; d_rs2 = 1'b1;
                unique case (f3)
                    3'd0: d_op = OP_BEQ;
                    3'd1: d_op = OP_BNE;
                    3'd4: d_op = OP_BLT;
                    3'd5: d_op = OP_BGE;
                    3'd6: d_op = OP_BLTU;
                    3'd7: d_op = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            7'h03: begin
                d_unit = U_MEM; d_op = OP_LOAD; d_imm = i_imm;
                d_rs1 = 1'b1; d_wr = 1'b1; d_msize = f3[1:0];
                d_msgn = ~f3[2]; ill = f3 == 3'd7;
            end
            7'h23: begin
                d_unit = U_MEM; d_op = OP_STORE; d_imm = s_imm;
                d_rs1 = 1'b1; d_rs2 = 1'b1; d_msize = f3[1:0];
                ill = f3[2];
            end
            7'h0F: begin
                d_unit = U_SYS; d_op = OP_FENCE; d_imm = i_imm;
                ill = f3[2:1] != 2'd0;
            end
            7'h73: begin
                d_unit = U_SYS; d_op = OP_SYS; d_imm = i_imm;
                d_rs1 = (f3 != 3'd0) && !f3[2]; ill = f3 == 3'd4;
            end
            default: ill = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) ill = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.valid_o <= 1'b0; bus.pc_o <= '0;
            bus.rs1_o <= '0; bus.rs2_o <= '0; bus.rd_o <= '0;
            bus.use_rs1_o <= 1'b0; bus.use_rs2_o <= 1'b0;
            bus.regfile_we_o <= 1'b0; bus.imm_o <= '0;
            bus.use_imm_o <= 1'b0; bus.use_pc_o <= 1'b0;
            bus.unit_o <= '0; bus.op_o <= '0;
            bus.mem_size_o <= '0; bus.mem_signed_o <= 1'b0;
            bus.ex_valid_o <= 1'b0; bus.ex_cause_o <= '0;
            bus.ex_origin_o <= '0;
            bus.bpred_taken_o <= 1'b0; bus.bpred_addr_o <= '0;
        end else begin
            bus.valid_o <= bus.valid_i; bus.pc_o <= bus.pc_i;
            bus.rs1_o <= inst[19:15]; bus.rs2_o <= inst[24:20];
            bus.rd_o <= inst[11:7];
            bus.use_rs1_o <= d_rs1; bus.use_rs2_o <= d_rs2;
            bus.regfile_we_o <= d_wr && !ill && (inst[11:7] != 5'd0);
            bus.imm_o <= d_imm;
            bus.use_imm_o <= d_uimm; bus.use_pc_o <= d_upc;
            bus.unit_o <= d_unit; bus.op_o <= d_op;
            bus.mem_size_o <= d_msize; bus.mem_signed_o <= d_msgn;
            bus.bpred_taken_o <= bus.bpred_taken_i;
            bus.bpred_addr_o <= bus.bpred_addr_i;
            // fetch faults outrank illegal-instruction detection
            if (!bus.valid_i) begin
                bus.ex_valid_o <= 1'b0; bus.ex_cause_o <= '0;
                bus.ex_origin_o <= '0;
            end else if (bus.ex_valid_i) begin
                bus.ex_valid_o <= 1'b1; bus.ex_cause_o <= bus.ex_cause_i;
                bus.ex_origin_o <= bus.ex_origin_i;
            end else if (ill) begin
                bus.ex_valid_o <= 1'b1; bus.ex_cause_o <= 4'd2;
                bus.ex_origin_o <= {{(XLEN-32){1'b0}}, inst};
            end else begin
                bus.ex_valid_o <= 1'b0; bus.ex_cause_o <= '0;
                bus.ex_origin_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rv64_decode_unit.sv
// Directed-vector bench for rv64_decode_unit: reset, ALU/branch/mem
// decode, immediates, illegal detection and exception priority.
module tb_rv64_decode_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rv64_decode_unit_if #(.PC_W(40), .XLEN(64)) bus ();

    rv64_decode_unit #(.PC_W(40), .XLEN(64)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [39:0] pc, input logic [31:0] ins,
                         input logic v, input logic exv,
                         input logic [3:0] exc, input logic [63:0] exo);
        @(negedge clk);
        bus.valid_i = v; bus.pc_i = pc; bus.inst_i = ins;
        bus.ex_valid_i = exv; bus.ex_cause_i = exc; bus.ex_origin_i = exo;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.pc_i = '0; bus.inst_i = 32'h0000_0013;
        bus.ex_valid_i = 1'b0; bus.ex_cause_i = '0; bus.ex_origin_i = '0;
        bus.bpred_taken_i = 1'b0; bus.bpred_addr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_imm", bus.imm_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        drive(40'h2010, 32'hFFF02013, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("slti_valid", 64'(bus.valid_o), 64'd1);
        chk("slti_pc", 64'(bus.pc_o), 64'h2010);
        chk("slti_unit", 64'(bus.unit_o), 64'd0);
        chk("slti_op", 64'(bus.op_o), 64'd3);
        chk("slti_rs1", 64'(bus.rs1_o), 64'd0);
        chk("slti_rd", 64'(bus.rd_o), 64'd0);
        chk("slti_imm", bus.imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("slti_uimm", 64'(bus.use_imm_o), 64'd1);
        chk("slti_we", 64'(bus.regfile_we_o), 64'd0);
        chk("slti_ex", 64'(bus.ex_valid_o), 64'd0);

        drive(40'h2014, 32'h00500013, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("addi_op", 64'(bus.op_o), 64'd0);
        chk("addi_imm", bus.imm_o, 64'd5);

        drive(40'h2018, 32'h00804013, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("xori_op", 64'(bus.op_o), 64'd5);
        chk("xori_imm", bus.imm_o, 64'd8);

        drive(40'h201C, 32'h00003013, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("sltiu_op", 64'(bus.op_o), 64'd4);
        chk("sltiu_imm", bus.imm_o, 64'd0);

        drive(40'h2020, 32'h00000000, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("ill_exv", 64'(bus.ex_valid_o), 64'd1);
        chk("ill_cause", 64'(bus.ex_cause_o), 64'd2);
        chk("ill_origin", bus.ex_origin_o, 64'd0);

        drive(40'h2024, 32'h00000000, 1'b1, 1'b1, 4'd1, 64'h1234);
        chk("fex_exv", 64'(bus.ex_valid_o), 64'd1);
        chk("fex_cause", 64'(bus.ex_cause_o), 64'd1);
        chk("fex_origin", bus.ex_origin_o, 64'h1234);

        drive(40'h2028, 32'h40208133, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("sub_op", 64'(bus.op_o), 64'd1);
        chk("sub_rs1", 64'(bus.rs1_o), 64'd1);
        chk("sub_rs2", 64'(bus.rs2_o), 64'd2);
        chk("sub_rd", 64'(bus.rd_o), 64'd2);
        chk("sub_we", 64'(bus.regfile_we_o), 64'd1);
        chk("sub_uimm", 64'(bus.use_imm_o), 64'd0);
        chk("sub_urs2", 64'(bus.use_rs2_o), 64'd1);
        chk("sub_imm", bus.imm_o, 64'd0);

        drive(40'h202C, 32'h800000B7, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("lui_op", 64'(bus.op_o), 64'd15);
        chk("lui_imm", bus.imm_o, 64'hFFFF_FFFF_8000_0000);
        chk("lui_we", 64'(bus.regfile_we_o), 64'd1);

        drive(40'h2030, 32'h43F0D093, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("srai_op", 64'(bus.op_o), 64'd7);
        chk("srai_imm", bus.imm_o, 64'd63);
        chk("srai_ex", 64'(bus.ex_valid_o), 64'd0);

        bus.bpred_taken_i = 1'b1; bus.bpred_addr_i = 40'h3000;
        drive(40'h2034, 32'hFFDFF0EF, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("jal_unit", 64'(bus.unit_o), 64'd1);
        chk("jal_op", 64'(bus.op_o), 64'd17);
        chk("jal_imm", bus.imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal_upc", 64'(bus.use_pc_o), 64'd1);
        chk("jal_bpt", 64'(bus.bpred_taken_o), 64'd1);
        chk("jal_bpa", 64'(bus.bpred_addr_o), 64'h3000);
        bus.bpred_taken_i = 1'b0; bus.bpred_addr_i = '0;

        drive(40'h2038, 32'h0020B423, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("sd_unit", 64'(bus.unit_o), 64'd2);
        chk("sd_op", 64'(bus.op_o), 64'd26);
        chk("sd_imm", bus.imm_o, 64'd8);
        chk("sd_size", 64'(bus.mem_size_o), 64'd3);
        chk("sd_we", 64'(bus.regfile_we_o), 64'd0);

        drive(40'h203C, 32'h04001013, 1'b1, 1'b0, 4'd0, 64'd0);
        chk("slli_rsv_ex", 64'(bus.ex_valid_o), 64'd1);
        chk("slli_rsv_org", bus.ex_origin_o, 64'h0400_1013);

        drive(40'h2040, 32'h00000000, 1'b0, 1'b0, 4'd0, 64'd0);
        chk("inv_valid", 64'(bus.valid_o), 64'd0);
        chk("inv_ex", 64'(bus.ex_valid_o), 64'd0);

        drive(40'h2044, 32'h40208133, 1'b1, 1'b0, 4'd0, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.valid_o), 64'd0);
        chk("arst_rd", 64'(bus.rd_o), 64'd0);
        chk("arst_pc", 64'(bus.pc_o), 64'd0);
        @(posedge clk);
        #1;
        chk("hold_op", 64'(bus.op_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_valid", 64'(bus.valid_o), 64'd1);
        chk("rel_op", 64'(bus.op_o), 64'd1);
        chk("rel_pc", 64'(bus.pc_o), 64'h2044);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/rv64_decode_unit.md
Name: rv64_decode_unit

Overview:
- Instruction decoder of the DRAC RV64I core ID stage; sits between the fetch/IF-ID register and the issue/register-read logic.
- Takes a fetched 32-bit instruction with its PC, fetch exception and branch prediction.
- Produces a registered, fully decoded instruction entry: register indices, sign-extended immediate, functional unit, operation code, control flags and exception.

Parameters:
- PC_W, 40, width of instruction address.
- XLEN, 64, datapath and immediate width.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous reset, active high.
- valid_i  in  1  input instruction valid.
- pc_i  in  PC_W  instruction PC.
- inst_i  in  32  raw instruction.
- ex_valid_i  in  1  fetch exception present.
- ex_cause_i  in  4  fetch exception cause.
- ex_origin_i  in  XLEN  fetch exception tval.
- bpred_taken_i  in  1  predicted taken (0 = PRED_NOT_TAKEN).
- bpred_addr_i  in  PC_W  predicted target.
- valid_o  out  1  decoded entry valid.
- pc_o  out  PC_W  registered PC.
- rs1_o, rs2_o, rd_o  out  5 each  register indices (inst[19:15], [24:20], [11:7]).
- use_rs1_o, use_rs2_o  out  1 each  source operand read required.
- regfile_we_o  out  1  writes rd.
- imm_o  out  XLEN  sign-extended immediate.
- use_imm_o  out  1  operand B is imm_o.
- use_pc_o  out  1  operand A is pc_o.
- unit_o  out  2  0 = ALU, 1 = BRANCH, 2 = MEM, 3 = SYSTEM.
- op_o  out  5  operation code.
- mem_size_o  out  2  funct3[1:0] for loads/stores.
- mem_signed_o  out  1  ~funct3[2] for loads.
- ex_valid_o  out  1  exception.
- ex_cause_o  out  4  exception cause.
- ex_origin_o  out  XLEN  exception tval.
- bpred_taken_o  out  1  predicted taken, registered.
- bpred_addr_o  out  PC_W  predicted target, registered.

Behaviour:
- Combinational decode, then one output register: outputs reflect the inputs sampled at the previous rising edge (latency 1, no stall or handshake). valid_o = registered valid_i.
- Reset: all outputs 0, asynchronously and held while rst_i = 1. After release, the first edge loads decoded inputs.
- op_o codes:
  - ALU: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, ADDW 10, SUBW 11, SLLW 12, SRLW 13, SRAW 14, LUI 15, AUIPC 16.
  - BRANCH: JAL 17, JALR 18, BEQ 19, BNE 20, BLT 21, BGE 22, BLTU 23, BGEU 24.
  - MEM: LOAD 25, STORE 26.
  - SYSTEM: FENCE 27, SYSTEM 28.
- OP-IMM (0x13) and OP-IMM-32 (0x1B):
  - I-imm, use_imm = 1, use_rs1 = 1; map funct3 to the ALU op (W variant for 0x1B).
  - Shifts take shamt inst[25:20] (64-bit) or inst[24:20] (W).
  - SRAI when inst[30] = 1.
- OP (0x33) and OP-32 (0x3B): use_rs1 = use_rs2 = 1; SUB/SRA when funct7 = 0x20.
- LUI: U-imm sign-extended from bit 31.
- AUIPC: use_pc = 1, use_imm = 1.
- JAL: J-imm, use_pc = 1.
- JALR: I-imm, use_rs1 = 1.
- Branches: B-imm, both sources read, regfile_we = 0.
- LOAD: I-imm, use_rs1 = 1.
- STORE: S-imm, both sources read, regfile_we = 0.
- FENCE (0x0F) and SYSTEM (0x73): I-imm, unit 3, regfile_we = 0.
- regfile_we_o = instruction writes rd AND rd ≠ 0.
- imm_o = 0 for R-type.
- Illegal instructions set ex_valid_o = 1, ex_cause_o = 2, ex_origin_o = zero-extended inst_i. Illegal means:
  - unknown opcode;
  - inst[1:0] ≠ 2'b11;
  - invalid funct3/funct7 combination;
  - shift with reserved funct bits.
- Exception priority: an incoming fetch exception (ex_valid_i = 1) is passed through unchanged and takes priority over illegal-instruction detection.
- Fetch exception cause encoding: NONE = 0.
- When valid_i = 0, decoded fields are don't-care but must still be registered deterministically (same decode logic); ex_valid_o = 0.
- Branch prediction fields pass through registered.

Test Plan:
- Assert rst_i mid-operation -> all outputs 0 immediately; after release, next edge loads the current input.
- Input: pc 0x2010, inst 0xFFF02013 (slti x0,x0,-1), valid = 1, no exception, not-taken.
  - Required one cycle later: valid_o = 1, pc_o = 0x2010, unit 0, op SLT(3), rs1 = 0, rd = 0, imm_o = 0xFFFF_FFFF_FFFF_FFFF, use_imm = 1, regfile_we = 0, ex_valid = 0.
- Input: 0x00500013 (addi x0,x0,5) -> op ADD, imm 5.
- Input: 0x00804013 (xori x0,x0,8) -> op XOR, imm 8.
- Input: 0x00003013 (sltiu x0,x0,0) -> op SLTU, imm 0.
- Input: inst 0x00000000 -> ex_valid = 1, cause 2.
- Input: same inst 0x00000000 with ex_valid_i = 1, cause 1 -> cause 1 propagated.
- Input: 0x40208133 (sub x2,x1,x2) -> op SUB, rs1 = 1, rs2 = 2, rd = 2, regfile_we = 1, use_imm = 0.
